funcdowncounter: RTL and testbench

//  Loadable down-counter with terminal-count pulse; the count-down counterpart of the 2-bit hold/count
//  up-counter. Shares its control sense: funcin=1 holds, funcin=0 counts. Loaded with a start value,

---
 rtl/funcdowncounter.sv | 117 +++++++++++
 tb/tb_funcdowncounter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/funcdowncounter.sv
// funcdowncounter: loadable down-counter with a registered terminal-count pulse.
//
// A load starts the counter from loadval and captures loadval as the reload value.
// While running, funcin=0 decrements the count and funcin=1 holds it. When the count
// reaches its terminal step (1 -> next), tcout pulses for one cycle. The count then
// either stops at zero or restarts from the reload value, depending on reloadin.
//
// Ports:
//   clockin   in   1      rising-edge clock
//   resetin   in   1      synchronous, active-high reset (highest priority)
//   loadin    in   1      load strobe; loadval is sampled on this edge
//   loadval   in   WIDTH  start/reload value
//   funcin    in   1      1 = hold, 0 = count down
//   reloadin  in   1      1 = auto-reload at terminal count, 0 = stop at zero
//   qout      out  WIDTH  current count (registered)
//   zeroout   out  1      qout == 0
//   tcout     out  1      terminal-count pulse (registered, one cycle wide)
//   busyout   out  1      high while in the RUN state
module funcdowncounter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clockin,
  input  logic             resetin,
  input  logic             loadin,
  input  logic [WIDTH-1:0] loadval,
  input  logic             funcin,
  input  logic             reloadin,
  output logic [WIDTH-1:0] qout,
  output logic             zeroout,
  output logic             tcout,
  output logic             busyout
);

  localparam logic [WIDTH-1:0] CountZero = '0;
  localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // The count only moves while running; 0 and 1 both end the run.
  // A zero count in RUN cannot be reached, but is treated as terminal so the
  // counter can never decrement past zero.
  logic terminal;
  assign terminal = (count_q == CountOne) || (count_q == CountZero);

  // State register
  always_ff @(posedge clockin) begin
    if (resetin) begin
      state_q  <= StIdle;
      count_q  <= CountZero;
      reload_q <= CountZero;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (loadin) begin
      // Load wins over a coincident terminal edge, so no pulse is produced.
      count_d  = loadval;
      reload_d = loadval;
      state_d  = (loadval != CountZero) ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_d = CountZero;
        end
        StRun: begin
          if (!funcin) begin
            if (terminal) begin
              tc_d = (count_q == CountOne);
              if (reloadin) begin
                count_d = reload_q;
                state_d = StRun;
              end else begin
                count_d = CountZero;
                state_d = StIdle;
              end
            end else begin
              count_d = count_q - CountOne;
            end
          end
        end
        default: begin
          state_d = StIdle;
          count_d = CountZero;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    qout    = count_q;
    zeroout = (count_q == CountZero);
    tcout   = tc_q;
    busyout = (state_q == StRun);
  end

endmodule

// File: tb/tb_funcdowncounter.sv
// Bench for funcdowncounter: directed scenarios followed by randomized cycles,
// all outputs compared every cycle against a behavioural model of the counter.
module tb_funcdowncounter;

  localparam int unsigned W = 4;

  logic         clockin = 1'b0;
  logic         resetin = 1'b1;
  logic         loadin = 1'b0;
  logic [W-1:0] loadval = '0;
  logic         funcin = 1'b0;
  logic         reloadin = 1'b0;
  logic [W-1:0] qout;
  logic         zeroout;
  logic         tcout;
  logic         busyout;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state: remaining count, captured start value, running flag, pulse.
  int m_q = 0;
  int m_rel = 0;
  bit m_run = 0;
  bit m_tc = 0;

  funcdowncounter #(.WIDTH(W)) dut (
    .clockin (clockin),
    .resetin (resetin),
    .loadin  (loadin),
    .loadval (loadval),
    .funcin  (funcin),
    .reloadin(reloadin),
    .qout    (qout),
    .zeroout (zeroout),
    .tcout   (tcout),
    .busyout (busyout)
  );

  always #5 clockin = ~clockin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Counter behaviour stated in plain terms: a run counts N cycles then pulses.
  task automatic model_edge(input bit rst, input bit ld, input int lv, input bit fn,
                            input bit rl);
    if (rst) begin
      m_q = 0; m_rel = 0; m_run = 0; m_tc = 0;
    end else if (ld) begin
      m_q = lv; m_rel = lv; m_run = (lv != 0); m_tc = 0;
    end else if (m_run && !fn) begin
      if (m_q == 1) begin
        m_tc = 1;
        m_run = rl;
        m_q = rl ? m_rel : 0;
      end else begin
        m_q = m_q - 1;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"}, 32'(qout), 32'(m_q));
    check({tag, "_zero"}, 32'(zeroout), 32'(m_q == 0));
    check({tag, "_tc"}, 32'(tcout), 32'(m_tc));
    check({tag, "_busy"}, 32'(busyout), 32'(m_run));
  endtask

  task automatic step(input bit rst, input bit ld, input int lv, input bit fn, input bit rl,
                      input string tag);
    resetin = rst; loadin = ld; loadval = W'(lv); funcin = fn; reloadin = rl;
    @(posedge clockin);
    model_edge(rst, ld, lv, fn, rl);
    #1;
    check_model(tag);
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, "reset");
    check("reset_q_const", 32'(qout), 0);
    check("reset_zero_const", 32'(zeroout), 1);

    // 1: load 3, count to zero without reload
    step(0, 1, 3, 0, 0, "t1_load");
    check("t1_q3", 32'(qout), 3);
    step(0, 0, 0, 0, 0, "t1_c1");
    step(0, 0, 0, 0, 0, "t1_c2");
    check("t1_q1", 32'(qout), 1);
    check("t1_busy_before_end", 32'(busyout), 1);
    step(0, 0, 0, 0, 0, "t1_c3");
    check("t1_tc", 32'(tcout), 1);
    check("t1_busy_end", 32'(busyout), 0);
    step(0, 0, 0, 0, 0, "t1_after");
    check("t1_tc_once", 32'(tcout), 0);

    // 2: hold mid-count
    step(0, 1, 5, 0, 0, "t2_load");
    step(0, 0, 0, 0, 0, "t2_c1");
    step(0, 0, 0, 0, 0, "t2_c2");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "t2_hold");
    check("t2_hold_q", 32'(qout), 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "t2_run");
    check("t2_tc", 32'(tcout), 1);
    check("t2_end_q", 32'(qout), 0);

    // 3: auto-reload with value 2
    step(0, 1, 2, 0, 1, "t3_load");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, "t3_run");
    check("t3_q_reloaded", 32'(qout), 2);
    check("t3_tc", 32'(tcout), 1);
    check("t3_busy", 32'(busyout), 1);
    step(0, 0, 0, 0, 1, "t3_mid");
    check("t3_tc_gap", 32'(tcout), 0);

    // 4: load of zero stays idle
    step(0, 1, 0, 0, 0, "t4_load");
    check("t4_busy", 32'(busyout), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, "t4_idle");
    check("t4_q", 32'(qout), 0);

    // 5: load on terminal edge wins, then reset mid-count
    step(0, 1, 4, 0, 0, "t5_load");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "t5_run");
    check("t5_q1", 32'(qout), 1);
    step(0, 1, 6, 0, 0, "t5_reload");
    check("t5_q6", 32'(qout), 6);
    check("t5_no_tc", 32'(tcout), 0);
    step(0, 0, 0, 0, 0, "t5_c");
    step(1, 0, 0, 0, 0, "t5_reset");
    check("t5_reset_busy", 32'(busyout), 0);
    check("t5_reset_tc", 32'(tcout), 0);

    // 6: full-scale load, no wrap below zero
    step(0, 1, 15, 0, 0, "t6_load");
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, "t6_run");
    check("t6_tc", 32'(tcout), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "t6_idle");
    check("t6_nowrap", 32'(qout), 0);

    // Randomized cycles
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
